// File: rtl/demultiplexer_1_to_4_sequencer.sv
// Buffers {dest, data} items in a 4-deep FIFO and presents each one to a 1-to-4 demux
// for DWELL consecutive cycles, back to back while items are waiting.
module demultiplexer_1_to_4_sequencer #(
  parameter int unsigned DWELL = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic       in_data,
  input  logic [1:0] in_dest,
  output logic       in_ready,
  output logic       in,
  output logic [1:0] select_lines,
  output logic       active,
  output logic [2:0] fifo_count
);

  typedef enum logic {StIdle, StHold} state_e;

  localparam logic [3:0] DwellLoad = 4'(DWELL - 1);

  logic [2:0] mem_q [4];
  logic [1:0] wr_ptr_q, rd_ptr_q;
  logic [2:0] count_q;
  logic [3:0] dwell_q;
  state_e     state_q;
  logic       push, pop;
  logic [2:0] head;

  assign in_ready   = rst_n & (count_q != 3'd4);
  assign push       = in_valid & in_ready;
  // Pop is decided from the pre-edge count, so an item pushed this edge waits one cycle.
  assign pop        = (count_q != 3'd0) & ((state_q == StIdle) | (dwell_q == 4'd0));
  assign head       = mem_q[rd_ptr_q];
  assign fifo_count = count_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_dest, in_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 3'd1;
        2'b01:   count_q <= count_q - 3'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      dwell_q      <= 4'd0;
      in           <= 1'b0;
      select_lines <= 2'b00;
      active       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            state_q      <= StHold;
            dwell_q      <= DwellLoad;
            in           <= head[0];
            select_lines <= head[2:1];
            active       <= 1'b1;
          end
        end
        StHold: begin
          if (dwell_q != 4'd0) begin
            dwell_q <= dwell_q - 4'd1;
          end else if (pop) begin
            dwell_q      <= DwellLoad;
            in           <= head[0];
            select_lines <= head[2:1];
            active       <= 1'b1;
          end else begin
            // select_lines deliberately keeps the last destination.
            state_q <= StIdle;
            in      <= 1'b0;
            active  <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_demultiplexer_1_to_4_sequencer.sv
// Bench for the demux sequencer: instance 0 uses DWELL=4, instance 1 uses DWELL=1.
// A start-time schedule model is compared every cycle, plus hand-computed literal checks.
module tb_demultiplexer_1_to_4_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vld [2];
  logic       dat [2];
  logic [1:0] dst [2];
  logic       rdy [2];
  logic       din [2];
  logic       act [2];
  logic [1:0] sel [2];
  logic [2:0] cnt [2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  demultiplexer_1_to_4_sequencer #(.DWELL(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(vld[0]), .in_data(dat[0]), .in_dest(dst[0]),
    .in_ready(rdy[0]), .in(din[0]), .select_lines(sel[0]), .active(act[0]),
    .fifo_count(cnt[0])
  );

  demultiplexer_1_to_4_sequencer #(.DWELL(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(vld[1]), .in_data(dat[1]), .in_dest(dst[1]),
    .in_ready(rdy[1]), .in(din[1]), .select_lines(sel[1]), .active(act[1]),
    .fifo_count(cnt[1])
  );

  task automatic check(input string name, input int k, input int a, input int e);
    n_cmp++;
    if (a != e) begin
      n_bad++;
      $display("FAIL %s[dut%0d] got %0d want %0d at %0t", name, k, a, e, $time);
    end
  endtask

  // Model: each accepted item gets a start edge = max(accept edge + 1, end of previous item)
  // and is shown for DWELL cycles from there. FIFO holds items accepted but not yet started.
  int         cyc = 0;
  int         n_items [2];
  int         last_end [2];
  int         st [2][64];
  int         acc [2][64];
  logic [1:0] m_dst [2][64];
  logic       m_dat [2][64];

  function automatic int dw(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  function automatic int fcount(input int k, input int n);
    int c = 0;
    for (int j = 0; j < n_items[k]; j++) begin
      if (acc[k][j] <= n && st[k][j] > n) c++;
    end
    return c;
  endfunction

  always @(posedge clk) begin
    int s;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        n_items[k]  = 0;
        last_end[k] = 0;
      end else if (vld[k] && fcount(k, cyc - 1) < 4 && n_items[k] < 64) begin
        s = (cyc + 1 > last_end[k]) ? cyc + 1 : last_end[k];
        st[k][n_items[k]]    = s;
        acc[k][n_items[k]]   = cyc;
        m_dst[k][n_items[k]] = dst[k];
        m_dat[k][n_items[k]] = dat[k];
        last_end[k]          = s + dw(k);
        n_items[k]++;
      end
    end
  end

  always @(negedge clk) begin
    int ea, ei, es, ec;
    for (int k = 0; k < 2; k++) begin
      ea = 0; ei = 0; es = 0; ec = 0;
      if (rst_n) begin
        for (int j = 0; j < n_items[k]; j++) begin
          if (st[k][j] <= cyc) es = int'(m_dst[k][j]);
          if (st[k][j] <= cyc && cyc < st[k][j] + dw(k)) begin
            ea = 1;
            ei = int'(m_dat[k][j]);
          end
        end
        ec = fcount(k, cyc);
      end
      check("active", k, int'(act[k]), ea);
      check("in", k, int'(din[k]), ei);
      check("select_lines", k, int'(sel[k]), es);
      check("fifo_count", k, int'(cnt[k]), ec);
      check("in_ready", k, int'(rdy[k]), (rst_n && ec < 4) ? 1 : 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int n_act, m, base, saw_full, over;
    logic [1:0] d1 [3];
    for (int k = 0; k < 2; k++) begin
      vld[k] = 1'b0; dat[k] = 1'b0; dst[k] = 2'd0;
      n_items[k] = 0; last_end[k] = 0;
    end

    // Reset and release away from a clock edge.
    repeat (3) tick();
    check("reset_ready", 0, int'(rdy[0]), 0);
    #1 rst_n = 1'b1;
    #1;
    check("release_ready", 0, int'(rdy[0]), 1);
    check("release_ready", 1, int'(rdy[1]), 1);

    // Single item, DWELL=4: dest 2, data 1.
    vld[0] = 1'b1; dst[0] = 2'd2; dat[0] = 1'b1;
    tick();
    vld[0] = 1'b0;
    check("single_cnt", 0, int'(cnt[0]), 1);
    check("single_idle", 0, int'(act[0]), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("single_act", 0, int'(act[0]), 1);
      check("single_sel", 0, int'(sel[0]), 2);
      check("single_in", 0, int'(din[0]), 1);
    end
    tick();
    check("single_end_act", 0, int'(act[0]), 0);
    check("single_end_in", 0, int'(din[0]), 0);
    check("single_end_sel", 0, int'(sel[0]), 2);
    repeat (2) tick();

    // Back-to-back, DWELL=4: dests 0..3, data 1,0,1,1.
    n_act = 0; m = 0;
    for (int i = 0; i < 24; i++) begin
      if (i < 4) begin
        vld[0] = 1'b1; dst[0] = 2'(i); dat[0] = (i != 1);
      end else begin
        vld[0] = 1'b0;
      end
      tick();
      if (act[0]) begin
        check("b2b_sel", 0, int'(sel[0]), m / 4);
        check("b2b_in", 0, int'(din[0]), (m / 4 != 1) ? 1 : 0);
        m++;
        n_act++;
      end
    end
    check("b2b_active_cycles", 0, n_act, 16);

    // Full, DWELL=4: hold in_valid until 8 items are accepted; inputs change every cycle.
    base = n_items[0]; saw_full = 0; over = 0;
    vld[0] = 1'b1;
    for (int t = 0; t < 100 && n_items[0] < base + 8; t++) begin
      dst[0] = 2'(t);
      dat[0] = (t % 3 == 0);
      tick();
      if (!rdy[0]) saw_full = 1;
      if (cnt[0] > 3'd4) over = 1;
    end
    vld[0] = 1'b0;
    check("full_seen", 0, saw_full, 1);
    repeat (40) begin
      tick();
      if (cnt[0] > 3'd4) over = 1;
    end
    check("full_never_over", 0, over, 0);

    // Reset mid-operation: 3 queued, reset in 2nd cycle of the first item.
    for (int i = 0; i < 3; i++) begin
      vld[0] = 1'b1; dst[0] = 2'(i + 1); dat[0] = 1'b1;
      tick();
    end
    vld[0] = 1'b0;
    check("mid_act", 0, int'(act[0]), 1);
    check("mid_sel", 0, int'(sel[0]), 1);
    #1 rst_n = 1'b0;
    #1;
    check("async_act", 0, int'(act[0]), 0);
    check("async_in", 0, int'(din[0]), 0);
    check("async_sel", 0, int'(sel[0]), 0);
    check("async_cnt", 0, int'(cnt[0]), 0);
    check("async_ready", 0, int'(rdy[0]), 0);
    repeat (2) tick();
    #1 rst_n = 1'b1;
    #1;
    check("rerelease_ready", 0, int'(rdy[0]), 1);
    n_act = 0;
    repeat (12) begin
      tick();
      if (act[0]) n_act++;
    end
    check("no_stale", 0, n_act, 0);

    // DWELL=1: dests 3,0,1 on consecutive edges.
    d1 = '{2'd3, 2'd0, 2'd1};
    for (int i = 0; i < 3; i++) begin
      vld[1] = 1'b1; dst[1] = d1[i]; dat[1] = 1'b1;
      tick();
      if (i == 0) begin
        check("d1_first_idle", 1, int'(act[1]), 0);
      end else begin
        check("d1_act", 1, int'(act[1]), 1);
        check("d1_sel", 1, int'(sel[1]), int'(d1[i - 1]));
      end
    end
    vld[1] = 1'b0;
    tick();
    check("d1_act", 1, int'(act[1]), 1);
    check("d1_sel", 1, int'(sel[1]), 1);
    tick();
    check("d1_end_act", 1, int'(act[1]), 0);
    check("d1_end_sel", 1, int'(sel[1]), 1);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/demultiplexer_1_to_4_sequencer.md
DEMULTIPLEXER_1_TO_4_SEQUENCER -- requirements
Module: demultiplexer_1_to_4_sequencer

Interface
REQ-001 SHALL have parameter DWELL, default 4, meaning clock cycles each accepted item is presented to the 1-to-4 demultiplexer (legal range 1..15).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  upstream item valid.
REQ-005 SHALL have port in_data  input  1  data bit to route.
REQ-006 SHALL have port in_dest  input  2  destination channel, 0..3.
REQ-007 SHALL have port in_ready  output  1  sequencer can accept an item.
REQ-008 SHALL have port in  output  1  data bit driven to the demultiplexer input.
REQ-009 SHALL have port select_lines  output  2  select lines driven to the demultiplexer.
REQ-010 SHALL have port active  output  1  in/select_lines carry a valid item this cycle.
REQ-011 SHALL have port fifo_count  output  3  items stored in the FIFO, 0..4.

Function
REQ-012 SHALL buffer items {in_dest, in_data} in a 4-entry FIFO, preserving order.
REQ-013 SHALL accept an item on a rising edge where in_valid=1 and in_ready=1; no item is accepted otherwise.
REQ-014 SHALL drive in_ready = 1 when fifo_count<4 and rst_n=1, else 0.
REQ-015 SHALL implement the FIFO read and write pointers as 2-bit, wrapping 3->0.
REQ-016 SHALL not change fifo_count on an edge with simultaneous push and pop.
REQ-017 SHALL implement an FSM with states IDLE and HOLD.
REQ-018 In IDLE: active=0, in=0, and select_lines holds its last value.
REQ-019 IDLE with fifo_count>0: on the next edge, pop the head, load it into in/select_lines, set active=1, load the dwell counter with DWELL-1, and go to HOLD.
REQ-020 HOLD with dwell counter>0: decrement the counter; outputs are unchanged.
REQ-021 HOLD with dwell counter=0 and fifo_count>0: pop and load the next item on the same edge, with no idle gap.
REQ-022 HOLD with dwell counter=0 and fifo_count=0: go to IDLE with active=0 and in=0.
REQ-023 Each item SHALL be presented for exactly DWELL consecutive cycles.
REQ-024 Latency: an item accepted on edge N into an empty FIFO while in IDLE SHALL appear on the outputs after edge N+1.
REQ-025 An item accepted on the same edge as an IDLE pop with fifo_count=0 SHALL NOT be popped on that edge; it is popped on the following edge.
REQ-026 With DWELL=1, the sequencer SHALL present one item per cycle while the FIFO is non-empty.
REQ-027 An in_dest or in_data change while not accepted SHALL have no effect.

Reset
REQ-028 While rst_n=0, immediately and asynchronously: state=IDLE, FIFO pointers=0, fifo_count=0, dwell counter=0, in=0, select_lines=2'b00, active=0, in_ready=0.
REQ-029 Reset asserted mid-HOLD SHALL discard the current item and all buffered items.
REQ-030 After rst_n rises, in_ready SHALL be 1 and the first accept SHALL be possible on the next edge.

Verification
REQ-031 Reset: assert rst_n=0 mid-operation -> in=0, select_lines=00, active=0, fifo_count=0, in_ready=0 without waiting for a clock edge; release -> in_ready=1.
REQ-032 Single item, DWELL=4: push dest=2, data=1 on edge 1 -> select_lines=10, in=1, active=1 after edges 2..5; after edge 6, active=0 and in=0.
REQ-033 Back-to-back, DWELL=4: push dests 0,1,2,3 (data 1,0,1,1) on consecutive edges -> select_lines sequence 00,01,10,11, each held 4 cycles, 16 contiguous active cycles, data order 1,0,1,1.
REQ-034 Full, DWELL=4: hold in_valid=1 for 8 items -> in_ready=0 whenever fifo_count=4; all 8 items presented in order, none lost or duplicated; fifo_count never exceeds 4.
REQ-035 Reset mid-operation: with 3 items queued, pull rst_n low during the 2nd cycle of the first item -> outputs clear at once; after release, no stale item is ever presented.
REQ-036 DWELL=1: push 3 items (dest 3,0,1) -> select_lines 11,00,01 on 3 consecutive cycles, then active=0.
